twiddle_mult_pipe: RTL and testbench
====================================

// Module: twiddle_mult_pipe
// PURPOSE
//  Parametrised, pipelined complex twiddle multiplier for the FFT datapath.
//  Multiplies a complex sample by W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), or by its conjugate for IFFT.
//  k is selected per sample at run time. A quarter-wave coefficient ROM uses quadrant symmetry.
//  Sits between butterfly stages. Replaces the fixed per-angle twiddle constant blocks; valid/ready on both sides.
// PARAMETERS
//  DATA_WIDTH  18  signed width of in/out real and imag
//  COEF_WIDTH  18  signed coefficient width, Q1.(COEF_WIDTH-2); +1.0 = 2^(COEF_WIDTH-2)
//  LOG2N       6   FFT size N = 2^LOG2N; LOG2N >= 3
// PORTS
//  clk         in   1            clock, all state on rising edge
//  rst_n       in   1            asynchronous active-low reset
//  in_valid    in   1            input sample valid
//  in_ready    out  1            block can accept a sample this cycle
//  in_real     in   DATA_WIDTH   signed input real part
//  in_imag     in   DATA_WIDTH   signed input imag part
//  in_k        in   LOG2N        twiddle index k, 0..N-1
//  in_inverse  in   1            1 = multiply by conj(W_N^k) (IFFT)
//  out_valid   out  1            output sample valid
//  out_ready   in   1            downstream accepts output
//  out_real    out  DATA_WIDTH   signed result real part
//  out_imag    out  DATA_WIDTH   signed result imag part
//  out_sat     out  1            result was saturated (either part); qualified by out_valid
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid 0, out_real/out_imag 0, out_sat 0. Pipeline contents discarded mid-operation.
//  - Advance enable: en = ~out_valid | out_ready; in_ready = en. Transfer on in_valid & in_ready.
//  - When en=0 all stages hold, out_* stable. Bubbles are not collapsed.
//  - Latency: 4 cycles from accept edge to out_valid=1. Full throughput 1 sample/cycle while out_ready=1.
//  - ROM: N/4 entries, r=0..N/4-1: C[r]=round(2^(CW-2)*cos(2*pi*r/N)), S[r]=round(2^(CW-2)*sin(2*pi*r/N)).
//    Computed at elaboration by a constant function; no file.
//  - Quadrant q=k[LOG2N-1:LOG2N-2], r=k[LOG2N-3:0]. (cos,sin) =
//    q0: (C,S); q1: (-S,C); q2: (-C,-S); q3: (S,-C). in_inverse=1 negates sin.
//  - Stage 1: register sample, q, r, inverse; ROM read. Stage 2: select/negate cos,sin.
//    Stage 3: form the four products rere=xr*cos, imim=xi*sin, reim=xr*sin, imre=xi*cos,
//    each DATA_WIDTH+COEF_WIDTH bits.
//  - Stage 4 (output register):
//    re = rere+imim; im = imre-reim; each DATA_WIDTH+COEF_WIDTH+1 bits.
//    Round: add 2^(CW-3), then arithmetic shift right CW-2.
//    Saturate to [-2^(DW-1), 2^(DW-1)-1]. out_sat=1 if either part clipped.
//  - k=0 forward/inverse: output equals input exactly. Exact cases: -C[0] and -S[N/4 index] do not exceed range,
//    because +1.0 fits in COEF_WIDTH.
//  - No internal overflow before saturation; intermediate widths as stated.
//  - Simultaneous in/out transfer in the same cycle is legal and occurs at full throughput.
// TESTING (DW=CW=18, LOG2N=6; unity=65536, C[8]=S[8]=46341)
//  1 k=0, in=(100000,-100000), fwd -> out=(100000,-100000), sat=0, out_valid 4 cycles after accept.
//  2 k=16 (q1), in=(100000,-100000), fwd -> out=(-100000,-100000); inverse=1 -> (100000,100000).
//  3 k=8, in=(100000,-100000), fwd -> re=0, im clipped to -131072, sat=1;
//    in=(1000,0) -> (707,-707), sat=0.
//  4 Back-to-back 64 samples, k=0..63, out_ready=1 -> 64 outputs on consecutive cycles,
//    each within 1 LSB of a double-precision model.
//  5 out_ready low 5 cycles with pipeline full -> in_ready=0, outputs held stable,
//    no loss/duplication after release.
//  6 rst_n low mid-stream (async, between edges) -> out_valid=0 and outputs 0 immediately;
//    first post-reset sample appears after 4 cycles.

Source files
------------

// File: rtl/twiddle_mult_pipe.sv
// ---------------------------------------------------------------------------
// twiddle_mult_pipe
//
// Pipelined complex twiddle multiplier for the FFT datapath. Each accepted
// sample (in_real + j*in_imag) is multiplied by W_N^k = cos(2*pi*k/N) -
// j*sin(2*pi*k/N), or by its conjugate when in_inverse is set. The twiddle
// index k is chosen per sample. Only a quarter wave of cos/sin is stored;
// the other three quadrants come from sign/swap symmetry.
//
// Pipeline (one register level each, all advancing together on en):
//   stage 1 : capture sample, quadrant, inverse flag, quarter-wave ROM read
//   stage 2 : quadrant swap/negate and conjugation -> (cos, sin)
//   stage 3 : four real products
//   stage 4 : add/subtract, round to nearest, saturate (output register)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    input sample valid
//   in_ready    block can accept a sample this cycle
//   in_real     signed input real part        [DATA_WIDTH]
//   in_imag     signed input imaginary part   [DATA_WIDTH]
//   in_k        twiddle index 0..N-1          [LOG2N]
//   in_inverse  1 = multiply by conj(W_N^k)
//   out_valid   output sample valid
//   out_ready   downstream accepts the output
//   out_real    signed result real part       [DATA_WIDTH]
//   out_imag    signed result imaginary part  [DATA_WIDTH]
//   out_sat     either result part was clipped (qualified by out_valid)
// ---------------------------------------------------------------------------
module twiddle_mult_pipe #(
    parameter int DATA_WIDTH = 18,
    parameter int COEF_WIDTH = 18,
    parameter int LOG2N      = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    input  logic        [LOG2N-1:0]      in_k,
    input  logic                         in_inverse,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_real,
    output logic signed [DATA_WIDTH-1:0] out_imag,
    output logic                         out_sat
);

    localparam int  QUARTER = 2 ** (LOG2N - 2);
    localparam int  IDX_W   = LOG2N - 2;
    localparam int  PROD_W  = DATA_WIDTH + COEF_WIDTH;
    localparam int  SUM_W   = PROD_W + 1;
    localparam int  FRAC_W  = COEF_WIDTH - 2;
    localparam real PI      = 3.14159265358979323846;

    localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(2 ** (FRAC_W - 1));
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Series expansions keep the table generation free of math-library
    // system functions; angles never exceed pi/2, so 14 terms are far
    // beyond double precision.
    function automatic real taylor_sin(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real taylor_cos(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Quarter-wave table, entry r at bits [r*COEF_WIDTH +: COEF_WIDTH],
    // rounded to nearest with +1.0 = 2^FRAC_W.
    function automatic logic [QUARTER*COEF_WIDTH-1:0] build_table(input bit want_sin);
        logic [QUARTER*COEF_WIDTH-1:0] bits;
        real                           angle;
        real                           scaled;
        int                            rounded;
        bits = '0;
        for (int r = 0; r < QUARTER; r++) begin
            angle  = 2.0 * PI * real'(r) / real'(4 * QUARTER);
            scaled = (want_sin ? taylor_sin(angle) : taylor_cos(angle)) * real'(2 ** FRAC_W);
            if (scaled >= 0.0) begin
                rounded = $rtoi(scaled + 0.5);
            end else begin
                rounded = -$rtoi(0.5 - scaled);
            end
            bits[r*COEF_WIDTH +: COEF_WIDTH] = COEF_WIDTH'(rounded);
        end
        return bits;
    endfunction

    localparam logic [QUARTER*COEF_WIDTH-1:0] COS_BITS = build_table(1'b0);
    localparam logic [QUARTER*COEF_WIDTH-1:0] SIN_BITS = build_table(1'b1);

    logic signed [COEF_WIDTH-1:0] cos_rom [QUARTER];
    logic signed [COEF_WIDTH-1:0] sin_rom [QUARTER];

    for (genvar g = 0; g < QUARTER; g++) begin : g_rom
        assign cos_rom[g] = COS_BITS[g*COEF_WIDTH +: COEF_WIDTH];
        assign sin_rom[g] = SIN_BITS[g*COEF_WIDTH +: COEF_WIDTH];
    end

    // Round half up, then clip to the output range. Bit DATA_WIDTH of the
    // result flags that clipping happened.
    function automatic logic [DATA_WIDTH:0] round_sat(input logic signed [SUM_W-1:0] acc);
        logic signed [SUM_W-1:0] biased;
        logic signed [SUM_W-1:0] shifted;
        biased  = acc + ROUND_BIAS;
        shifted = biased >>> FRAC_W;
        if (shifted > SAT_MAX) begin
            return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        end else if (shifted < SAT_MIN) begin
            return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        end else begin
            return {1'b0, shifted[DATA_WIDTH-1:0]};
        end
    endfunction

    logic                         en;
    logic        [1:0]            k_quad;
    logic        [IDX_W-1:0]      k_idx;

    logic                         s1_valid;
    logic signed [DATA_WIDTH-1:0] s1_real;
    logic signed [DATA_WIDTH-1:0] s1_imag;
    logic        [1:0]            s1_quad;
    logic                         s1_inv;
    logic signed [COEF_WIDTH-1:0] s1_cos;
    logic signed [COEF_WIDTH-1:0] s1_sin;

    logic signed [COEF_WIDTH-1:0] sel_cos;
    logic signed [COEF_WIDTH-1:0] sel_sin;

    logic                         s2_valid;
    logic signed [DATA_WIDTH-1:0] s2_real;
    logic signed [DATA_WIDTH-1:0] s2_imag;
    logic signed [COEF_WIDTH-1:0] s2_cos;
    logic signed [COEF_WIDTH-1:0] s2_sin;

    logic                         s3_valid;
    logic signed [PROD_W-1:0]     s3_rere;
    logic signed [PROD_W-1:0]     s3_imim;
    logic signed [PROD_W-1:0]     s3_reim;
    logic signed [PROD_W-1:0]     s3_imre;

    logic signed [SUM_W-1:0]      sum_re;
    logic signed [SUM_W-1:0]      sum_im;
    logic        [DATA_WIDTH:0]   res_re;
    logic        [DATA_WIDTH:0]   res_im;

    // The whole pipeline moves as one unit: it may advance whenever the
    // output register is empty or is being drained this cycle. Bubbles are
    // carried along rather than squeezed out.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    assign k_quad = in_k[LOG2N-1 -: 2];
    assign k_idx  = in_k[IDX_W-1:0];

    // Quadrant mapping of the first-quarter (C, S) pair, followed by
    // conjugation for the inverse transform. Magnitudes never exceed +1.0,
    // which is representable, so negation cannot overflow.
    always_comb begin
        sel_cos = s1_cos;
        sel_sin = s1_sin;
        case (s1_quad)
            2'd0: begin
                sel_cos = s1_cos;
                sel_sin = s1_sin;
            end
            2'd1: begin
                sel_cos = -s1_sin;
                sel_sin = s1_cos;
            end
            2'd2: begin
                sel_cos = -s1_cos;
                sel_sin = -s1_sin;
            end
            default: begin
                sel_cos = s1_sin;
                sel_sin = -s1_cos;
            end
        endcase
        if (s1_inv) begin
            sel_sin = -sel_sin;
        end
    end

    // (xr + j*xi) * (cos - j*sin) = (xr*cos + xi*sin) + j*(xi*cos - xr*sin)
    always_comb begin
        sum_re = SUM_W'(s3_rere) + SUM_W'(s3_imim);
        sum_im = SUM_W'(s3_imre) - SUM_W'(s3_reim);
        res_re = round_sat(sum_re);
        res_im = round_sat(sum_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_real  <= '0;
            s1_imag  <= '0;
            s1_quad  <= '0;
            s1_inv   <= 1'b0;
            s1_cos   <= '0;
            s1_sin   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_real  <= in_real;
            s1_imag  <= in_imag;
            s1_quad  <= k_quad;
            s1_inv   <= in_inverse;
            s1_cos   <= cos_rom[k_idx];
            s1_sin   <= sin_rom[k_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_real  <= '0;
            s2_imag  <= '0;
            s2_cos   <= '0;
            s2_sin   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_real  <= s1_real;
            s2_imag  <= s1_imag;
            s2_cos   <= sel_cos;
            s2_sin   <= sel_sin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_rere  <= '0;
            s3_imim  <= '0;
            s3_reim  <= '0;
            s3_imre  <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_rere  <= PROD_W'(s2_real) * PROD_W'(s2_cos);
            s3_imim  <= PROD_W'(s2_imag) * PROD_W'(s2_sin);
            s3_reim  <= PROD_W'(s2_real) * PROD_W'(s2_sin);
            s3_imre  <= PROD_W'(s2_imag) * PROD_W'(s2_cos);
        end
    end

    // Saturation flag is forced low for bubbles so it never reports a
    // clip on a slot that carries no sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s3_valid;
            out_real  <= res_re[DATA_WIDTH-1:0];
            out_imag  <= res_im[DATA_WIDTH-1:0];
            out_sat   <= s3_valid & (res_re[DATA_WIDTH] | res_im[DATA_WIDTH]);
        end
    end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_twiddle_mult_pipe
//
// Self-checking bench for twiddle_mult_pipe (DW=CW=18, LOG2N=6). Expected
// results come from a reference model that applies the complex product,
// round-half-up and clipping rules with plain 64-bit arithmetic, plus a
// double-precision model used as a tolerance check on the k sweep. A
// negedge monitor scoreboards every output transfer in order.
// ---------------------------------------------------------------------------
module tb_twiddle_mult_pipe;

    localparam int     DW    = 18;
    localparam int     CW    = 18;
    localparam int     LG    = 6;
    localparam int     N     = 1 << LG;
    localparam int     QTR   = N / 4;
    localparam int     FRAC  = CW - 2;
    localparam real    UNITY = 65536.0;
    localparam real    PI    = 3.14159265358979323846;
    localparam longint MAXV  = 131071;
    localparam longint MINV  = -131072;
    localparam longint HALF  = 32768;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic        [LG-1:0] in_k;
    logic                 in_inverse;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic                 out_sat;

    twiddle_mult_pipe #(
        .DATA_WIDTH(DW),
        .COEF_WIDTH(CW),
        .LOG2N     (LG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_k      (in_k),
        .in_inverse(in_inverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
        logic               sat;
        logic               tol;
        logic signed [31:0] dre256;
        logic signed [31:0] dim256;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks       = 0;
    int     errors       = 0;
    int     cyc          = 0;
    int     out_count    = 0;
    int     last_out_cyc = -10;
    int     gap_count    = 0;
    bit     drv_done     = 1'b0;
    longint diff_re;
    longint diff_im;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // First-quadrant table value, round to nearest.
    function automatic longint tbl(input int r, input bit want_sin);
        real a;
        real v;
        a = 2.0 * PI * real'(r) / real'(N);
        v = (want_sin ? $sin(a) : $cos(a)) * UNITY;
        if (v >= 0.0) return longint'($rtoi(v + 0.5));
        return -longint'($rtoi(0.5 - v));
    endfunction

    function automatic exp_t model(input int xr, input int xi, input int k, input bit inv, input bit tol);
        exp_t   e;
        longint c, s, cs, sn, re, im;
        real    th, sv, dre, dim;
        int     q, r;
        q = k / QTR;
        r = k % QTR;
        c = tbl(r, 1'b0);
        s = tbl(r, 1'b1);
        case (q)
            0:       begin cs = c;  sn = s;  end
            1:       begin cs = -s; sn = c;  end
            2:       begin cs = -c; sn = -s; end
            default: begin cs = s;  sn = -c; end
        endcase
        if (inv) sn = -sn;
        re = (longint'(xr) * cs + longint'(xi) * sn + HALF) >>> FRAC;
        im = (longint'(xi) * cs - longint'(xr) * sn + HALF) >>> FRAC;
        e.sat = (re > MAXV) || (re < MINV) || (im > MAXV) || (im < MINV);
        if (re > MAXV) re = MAXV;
        if (re < MINV) re = MINV;
        if (im > MAXV) im = MAXV;
        if (im < MINV) im = MINV;
        e.re  = 32'(re);
        e.im  = 32'(im);
        e.tol = tol;
        th    = 2.0 * PI * real'(k) / real'(N);
        sv    = inv ? -$sin(th) : $sin(th);
        dre   = real'(xr) * $cos(th) + real'(xi) * sv;
        dim   = real'(xi) * $cos(th) - real'(xr) * sv;
        e.dre256 = $rtoi(dre * 256.0);
        e.dim256 = $rtoi(dim * 256.0);
        return e;
    endfunction

    // Output scoreboard: a transfer happens on the next rising edge when
    // out_valid and out_ready are both high at this falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_real", out_real, mon_e.re);
                checkOutput("sb_imag", out_imag, mon_e.im);
                checkOutput("sb_sat", out_sat, mon_e.sat);
                if (mon_e.tol) begin
                    diff_re = longint'(out_real) * 256 - longint'(mon_e.dre256);
                    diff_im = longint'(out_imag) * 256 - longint'(mon_e.dim256);
                    checkOutput("tol_real", (diff_re <= 256 && diff_re >= -256) ? 1 : 0, 1);
                    checkOutput("tol_imag", (diff_im <= 256 && diff_im >= -256) ? 1 : 0, 1);
                end
            end
            out_count++;
            if (cyc != last_out_cyc + 1) gap_count++;
            last_out_cyc = cyc;
        end
    end

    // Called and returns one ns after a rising edge; returns one ns after
    // the edge that accepted the sample.
    task automatic applyStimulus(input int xr, input int xi, input int k, input bit inv, input bit tol);
        int  waited;
        bit  done;
        waited     = 0;
        done       = 1'b0;
        in_real    = DW'(xr);
        in_imag    = DW'(xi);
        in_k       = LG'(k);
        in_inverse = inv;
        in_valid   = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                exp_q.push_back(model(xr, xi, k, inv, tol));
                done = 1'b1;
            end else if (waited > 200) begin
                checkOutput("accept_timeout", 0, 1);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid(input string tag, output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) checkOutput(tag, 0, 1);
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, exp_q.size(), 0);
    endtask

    // Single sample through an empty pipe with known result; the latency is
    // counted in rising edges including the accepting edge.
    task automatic runDirected(input string tag, input int xr, input int xi, input int k, input bit inv,
                               input int ere, input int eim, input bit esat);
        int edges;
        applyStimulus(xr, xi, k, inv, 1'b0);
        waitOutValid({tag, "_timeout"}, edges);
        checkOutput({tag, "_latency"}, edges + 1, 4);
        checkOutput({tag, "_re"}, out_real, ere);
        checkOutput({tag, "_im"}, out_imag, eim);
        checkOutput({tag, "_sat"}, out_sat, esat);
        @(posedge clk);
        #1;
    endtask

    function automatic int rndFull();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, %0d checks so far", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int g0;
        int n;
        int xr;
        int xi;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_real    = '0;
        in_imag    = '0;
        in_k       = '0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_real", out_real, 0);
        checkOutput("reset_out_imag", out_imag, 0);
        checkOutput("reset_out_sat", out_sat, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed cases");
        runDirected("k0_fwd", 100000, -100000, 0, 1'b0, 100000, -100000, 1'b0);
        runDirected("k0_inv", 100000, -100000, 0, 1'b1, 100000, -100000, 1'b0);
        runDirected("k16_fwd", 100000, -100000, 16, 1'b0, -100000, -100000, 1'b0);
        runDirected("k16_inv", 100000, -100000, 16, 1'b1, 100000, 100000, 1'b0);
        runDirected("k8_clip", 100000, -100000, 8, 1'b0, 0, -131072, 1'b1);
        runDirected("k8_small", 1000, 0, 8, 1'b0, 707, -707, 1'b0);
        runDirected("k32_posclip", -131072, 5, 32, 1'b0, 131071, -5, 1'b1);
        runDirected("k48_fwd", 3, -7, 48, 1'b0, 7, 3, 1'b0);

        $display("[TB] back-to-back k sweep");
        base = out_count;
        g0   = 0;
        fork
            begin
                for (int k = 0; k < N; k++) begin
                    applyStimulus(int'($urandom_range(0, 40000)) - 20000,
                                  int'($urandom_range(0, 40000)) - 20000, k, 1'b0, 1'b1);
                end
            end
            begin
                n = 0;
                while (out_count < base + 1 && n < 300) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                g0 = gap_count;
                n  = 0;
                while (out_count < base + N && n < 300) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        checkOutput("b2b_count", out_count - base, N);
        checkOutput("b2b_gaps", gap_count - g0, 0);
        waitDrain("b2b_drain");

        $display("[TB] output stall with full pipeline");
        base = out_count;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    applyStimulus(rndFull(), rndFull(), int'($urandom_range(0, N - 1)),
                                  1'($urandom_range(0, 1)), 1'b0);
                end
            end
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                checkOutput("stall_in_ready", in_ready, 0);
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    checkOutput("stall_in_ready_hold", in_ready, 0);
                    checkOutput("stall_out_valid", out_valid, 1);
                    if (exp_q.size() == 0) begin
                        checkOutput("stall_front_present", 0, 1);
                    end else begin
                        checkOutput("stall_hold_real", out_real, exp_q[0].re);
                        checkOutput("stall_hold_imag", out_imag, exp_q[0].im);
                        checkOutput("stall_hold_sat", out_sat, exp_q[0].sat);
                    end
                end
                out_ready = 1'b1;
            end
        join
        waitDrain("stall_drain");
        checkOutput("stall_count", out_count - base, 24);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(rndFull(), rndFull(), int'($urandom_range(0, N - 1)), 1'b0, 1'b0);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_out_real", out_real, 0);
        checkOutput("arst_out_imag", out_imag, 0);
        checkOutput("arst_out_sat", out_sat, 0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
            checkOutput("arst_flushed", out_valid, 0);
        end
        runDirected("post_reset", 1000, 0, 8, 1'b0, 707, -707, 1'b0);

        $display("[TB] random traffic with backpressure");
        base     = out_count;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    xr = rndFull();
                    xi = rndFull();
                    applyStimulus(xr, xi, int'($urandom_range(0, N - 1)),
                                  1'($urandom_range(0, 1)), 1'b0);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        waitDrain("random_drain");
        checkOutput("random_count", out_count - base, 300);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
